// File: rtl/prio_pkg.sv
// rtl/prio_pkg.sv - shared mode encodings and index-width helper for prio_enc_rr
package prio_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index width for an n-line encoder; at least one bit even for degenerate n.
  function automatic int calc_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_find_hi.sv
// rtl/prio_find_hi.sv - combinational highest-set-bit finder
// Ports:
//   vec   in  N  vector to search
//   idx   out W  index of the highest set bit (0 when none found)
//   found out 1  at least one bit of vec is set
module prio_find_hi
  import prio_pkg::*;
#(
  parameter  int N = 16,
  localparam int W = calc_w(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         found
);

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_enc_rr.sv
// rtl/prio_enc_rr.sv - registered N-input priority encoder, fixed or round-robin per transaction
// Ports:
//   clk       in  1  clock, rising edge
//   rst_n     in  1  asynchronous active-low reset
//   req       in  N  request vector, sampled on accept
//   mode      in  1  MODE_FIXED (highest index wins) or MODE_RR (rotating pointer)
//   in_valid  in  1  req/mode valid
//   in_ready  out 1  block can accept this cycle
//   out_valid out 1  idx/onehot/none valid
//   out_ready in  1  consumer takes the result
//   idx       out W  winning index (0 when none)
//   onehot    out N  1<<idx, zero when none
//   none      out 1  sampled req was all zero
module prio_enc_rr
  import prio_pkg::*;
#(
  parameter  int N = 16,
  localparam int W = calc_w(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot,
  output logic         none
);

  logic [W-1:0] ptr;
  logic [N-1:0] rot;
  logic [N-1:0] search;
  logic [W-1:0] hi_idx;
  logic         found;
  logic [W-1:0] win;
  logic         accept;

  // Operands here never exceed 2N-1, so one conditional subtract is a full mod N.
  function automatic int wrap_n(input int v);
    return (v >= N) ? v - N : v;
  endfunction

  // Rotate left so req[ptr] lands at bit N-1; a descending search of rot then
  // visits ptr, ptr-1, ..., 0, N-1, ..., ptr+1. Works for any N, not only 2^k.
  always_comb begin
    rot = '0;
    for (int j = 0; j < N; j++) begin
      rot[j] = req[wrap_n(j + int'(ptr) + 1)];
    end
  end

  assign search = (mode == MODE_RR) ? rot : req;

  prio_find_hi #(.N(N)) u_find (
    .vec   (search),
    .idx   (hi_idx),
    .found (found)
  );

  // Undo the rotation: bit j of rot came from req[(j + ptr + 1) mod N].
  assign win = (mode == MODE_RR) ? W'(wrap_n(int'(hi_idx) + int'(ptr) + 1)) : hi_idx;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      idx       <= '0;
      onehot    <= '0;
      none      <= 1'b0;
      ptr       <= W'(N - 1);
    end else if (accept) begin
      out_valid <= 1'b1;
      idx       <= found ? win : '0;
      onehot    <= found ? (N'(1) << win) : '0;
      none      <= !found;
      // Next search starts just below the winner, wrapping to N-1.
      if (found && (mode == MODE_RR)) begin
        ptr <= (win == '0) ? W'(N - 1) : win - W'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prio_enc_rr.sv
// tb/tb_prio_enc_rr.sv - self-checking bench for prio_enc_rr at N=16 and N=5
module tb_prio_enc_rr;

  logic clk;

  logic        rst16_n, m16, iv16, ir16, ov16, or16, none16;
  logic [15:0] req16, oh16;
  logic [3:0]  idx16;

  logic        rst5_n, m5, iv5, ir5, ov5, or5, none5;
  logic [4:0]  req5, oh5;
  logic [2:0]  idx5;

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0 = N=16 instance, 1 = N=5 instance.
  bit          mv [2];
  int          mi [2];
  logic [15:0] mo [2];
  bit          mn [2];
  int          mp [2];

  prio_enc_rr #(.N(16)) u16 (
    .clk(clk), .rst_n(rst16_n), .req(req16), .mode(m16), .in_valid(iv16),
    .in_ready(ir16), .out_valid(ov16), .out_ready(or16), .idx(idx16),
    .onehot(oh16), .none(none16)
  );

  prio_enc_rr #(.N(5)) u5 (
    .clk(clk), .rst_n(rst5_n), .req(req5), .mode(m5), .in_valid(iv5),
    .in_ready(ir5), .out_valid(ov5), .out_ready(or5), .idx(idx5),
    .onehot(oh5), .none(none5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nlines(input int k);
    return (k == 0) ? 16 : 5;
  endfunction

  task automatic model_reset(input int k);
    mv[k] = 0; mi[k] = 0; mo[k] = '0; mn[k] = 0; mp[k] = nlines(k) - 1;
  endtask

  // Walk the priority order directly: fixed starts at n-1, RR at the pointer,
  // both descending modulo n; first requesting line wins.
  task automatic pick(input logic [15:0] r, input int n, input bit m, inout int p,
                      output int w, output bit f);
    int start;
    start = m ? p : n - 1;
    w = 0;
    f = 0;
    for (int s = 0; s < n; s++) begin
      int k;
      k = (start - s + n) % n;
      if (!f && r[k]) begin
        w = k;
        f = 1;
      end
    end
    if (f && m) p = (w == 0) ? n - 1 : w - 1;
  endtask

  task automatic model_step(input int k, input bit v, input logic [15:0] r,
                            input bit m, input bit ordy);
    int w;
    bit f;
    if (v && (!mv[k] || ordy)) begin
      pick(r, nlines(k), m, mp[k], w, f);
      mv[k] = 1;
      mi[k] = f ? w : 0;
      mo[k] = f ? (16'h1 << w) : 16'h0;
      mn[k] = !f;
    end else if (ordy) begin
      mv[k] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, iv16, req16, m16, or16);
    model_step(1, iv5, {11'b0, req5}, m5, or5);
    #1;
  endtask

  // One clock of traffic on instance u; called at posedge+1.
  task automatic cyc(input int u, input bit v, input logic [15:0] r, input bit m,
                     input bit ordy, input string tag);
    if (u == 0) begin
      iv16 = v; req16 = r; m16 = m; or16 = ordy;
    end else begin
      iv5 = v; req5 = r[4:0]; m5 = m; or5 = ordy;
    end
    #1;
    chk({tag, ".in_ready"}, (u == 0) ? 32'(ir16) : 32'(ir5), 32'(!mv[u] || ordy));
    tick();
    if (u == 0) begin
      chk({tag, ".out_valid"}, 32'(ov16), 32'(mv[0]));
      chk({tag, ".idx"},       32'(idx16), 32'(mi[0]));
      chk({tag, ".onehot"},    32'(oh16), 32'(mo[0]));
      chk({tag, ".none"},      32'(none16), 32'(mn[0]));
    end else begin
      chk({tag, ".out_valid"}, 32'(ov5), 32'(mv[1]));
      chk({tag, ".idx"},       32'(idx5), 32'(mi[1]));
      chk({tag, ".onehot"},    32'(oh5), 32'(mo[1][4:0]));
      chk({tag, ".none"},      32'(none5), 32'(mn[1]));
    end
  endtask

  initial begin
    rst16_n = 1'b0; rst5_n = 1'b0;
    req16 = '0; m16 = 1'b0; iv16 = 1'b0; or16 = 1'b1;
    req5  = '0; m5  = 1'b0; iv5  = 1'b0; or5  = 1'b1;
    model_reset(0);
    model_reset(1);

    #12;
    chk("rst.out_valid", 32'(ov16), 32'd0);
    chk("rst.idx",       32'(idx16), 32'd0);
    chk("rst.onehot",    32'(oh16), 32'd0);
    chk("rst.none",      32'(none16), 32'd0);
    chk("rst.in_ready",  32'(ir16), 32'd1);
    @(posedge clk); #1;
    rst16_n = 1'b1;
    rst5_n  = 1'b1;

    // Pointer starts at 15: lone bit 0 in RR wins with idx 0.
    cyc(0, 1, 16'h0001, 1, 1, "rst_ptr");
    chk("rst_ptr.const", 32'(idx16), 32'd0);

    cyc(0, 1, 16'h0101, 0, 1, "fix_a");
    chk("fix_a.const", 32'(idx16), 32'd8);
    cyc(0, 1, 16'h0001, 0, 1, "fix_b");
    cyc(0, 1, 16'h0000, 0, 1, "fix_zero");
    chk("fix_zero.const", 32'(none16), 32'd1);

    for (int i = 0; i < 4; i++) cyc(0, 1, 16'h8101, 1, 1, "rr_seq");
    chk("rr_seq.const", 32'(idx16), 32'd15);
    cyc(0, 1, 16'h8101, 0, 1, "rr_fixed");
    cyc(0, 1, 16'h8101, 1, 1, "rr_resume");
    chk("rr_resume.const", 32'(idx16), 32'd8);
    cyc(0, 0, 16'h0000, 0, 1, "drain");

    // Backpressure: hold the output for three cycles with a new request waiting.
    cyc(0, 1, 16'h0f0f, 1, 0, "bp_load");
    for (int i = 0; i < 3; i++) cyc(0, 1, 16'h00f3, 1, 0, "bp_hold");
    cyc(0, 1, 16'h00f3, 1, 1, "bp_release");
    cyc(0, 0, 16'h0000, 0, 1, "bp_drain");

    // Non-power-of-two N: pointer wraps 0 -> 4.
    for (int i = 0; i < 3; i++) cyc(1, 1, 16'h0011, 1, 1, "n5_rr");
    chk("n5_rr.const", 32'(idx5), 32'd4);
    cyc(1, 0, 16'h0000, 0, 1, "n5_drain");

    // Asynchronous reset mid-cycle while a result is pending.
    cyc(1, 1, 16'h0011, 1, 0, "ar_load");
    iv5 = 1'b0;
    #3;
    rst5_n = 1'b0;
    model_reset(1);
    #1;
    chk("ar.out_valid", 32'(ov5), 32'd0);
    chk("ar.idx",       32'(idx5), 32'd0);
    chk("ar.onehot",    32'(oh5), 32'd0);
    tick();
    rst5_n = 1'b1;
    cyc(1, 0, 16'h0000, 0, 1, "ar_idle");
    cyc(1, 0, 16'h0000, 0, 1, "ar_idle");
    cyc(1, 1, 16'h0011, 1, 1, "ar_rr");
    chk("ar_rr.const", 32'(idx5), 32'd4);

    // Randomised traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      int u;
      logic [15:0] r;
      u = int'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       r = 16'h0000;
        1:       r = 16'h1 << $urandom_range(0, 15);
        default: r = 16'($urandom);
      endcase
      if (u == 1) r = r & 16'h001f;
      cyc(u, $urandom_range(0, 3) != 0, r, 1'($urandom_range(0, 1)),
          $urandom_range(0, 3) != 0, (u == 0) ? "rnd16" : "rnd5");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
